alu_scheduler: RTL and testbench
================================

Name: alu_scheduler

Overview:
- Shares one 8-bit ALU (ops: add, sub, and, or, xor, not, shl, shr, compare) among NUM_REQ requesters.
- Round-robin arbitration, one operation in flight at a time.
- Registers operands into the ALU and captures result and flags.
- Returns each result to the issuing requester via a valid/ready response channel tagged with the requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width; must match the ALU.
- OP_W, 4, opcode width.
- ID_W, 2, requester ID width = clog2(NUM_REQ).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  operand B, same packing.
- req_op  input  NUM_REQ*OP_W  opcode, same packing.
- alu_a  output  DATA_W  registered operand A to ALU.
- alu_b  output  DATA_W  registered operand B to ALU.
- alu_opcode  output  OP_W  registered opcode to ALU.
- alu_result  input  DATA_W  ALU combinational result.
- alu_overflow, alu_negative, alu_zero  input  1 each  ALU flags.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  ID_W  index of the issuing requester.
- resp_result  output  DATA_W  captured result.
- resp_flags  output  3  {overflow, negative, zero}, captured.
- resp_err  output  1  illegal opcode (4'b1001..4'b1111).
- busy  output  1  state != IDLE.
- ops_done  output  16  count of completed responses; wraps at 0xFFFF -> 0.

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready=0, resp_valid=0.
  - alu_a/alu_b/alu_opcode=0, resp_id=0, resp_result=0, resp_flags=0, resp_err=0.
  - busy=0, ops_done=0.
  - RR pointer = NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant = first set req_valid bit scanning from pointer+1 upward, wrapping modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally, others 0. Ready depends on valid; requesters must not wait on ready before asserting valid.
  - On the handshake edge: latch alu_a/b/opcode and resp_id from the granted slice; pointer <= grant.
  - Legal opcode -> EXEC. Illegal opcode -> RESP directly with resp_err=1, resp_result=0, resp_flags=0; alu_opcode is still latched.
- EXEC (exactly 1 cycle):
  - ALU evaluates the registered operands.
  - Next edge: resp_result <= alu_result, resp_flags <= {alu_overflow, alu_negative, alu_zero}, resp_err=0; -> RESP.
- RESP:
  - resp_valid=1; all resp_* held stable while resp_ready=0.
  - On resp_valid&resp_ready edge: ops_done += 1; -> IDLE.
  - resp_id/result/flags retain their last values after the handshake.
- Latency: accept edge E0, response visible in the cycle after E1 (2 edges). Illegal opcode: visible after E0 (1 edge). Minimum issue interval 3 cycles (legal) / 2 cycles (illegal).
- req_ready is 0 in EXEC and RESP; requests wait with valid held. Withdrawing valid before acceptance is allowed and has no effect.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,...; no requester waits more than NUM_REQ-1 grants.
- alu_a/b/opcode hold their last values outside EXEC.
- Reset mid-operation (EXEC or RESP): in-flight operation dropped, no response emitted, everything returns to reset values immediately.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams OP_ADD=0000, OP_SUB=0001, OP_AND=0010, OP_OR=0011, OP_XOR=0100, OP_NOT=0101, OP_SHL=0110, OP_SHR=0111, OP_CMP=1000, OP_LAST=OP_CMP.
  - Scheduler state enum {IDLE, EXEC, RESP}.
  - Flag-vector bit indices.
- Sub-module rr_arbiter: parameter N; inputs req and pointer; output one-hot grant and grant index. Purely combinational; the pointer register stays in alu_scheduler.

Test Plan:
- Req 0 only: A=50, B=20, op=0000 -> resp_id=0, resp_result=70, flags=000, resp_valid in the second cycle after acceptance; ops_done=1.
- All 4 valid continuously, ops distinct, resp_ready=1 -> grants in order 0,1,2,3,0; resp_id sequence matches; each accept is 3 cycles apart.
- Req 2: A=20, B=20, op=0001 -> resp_result=0, zero=1, negative=0, resp_err=0.
- Req 1: op=1010 -> resp_err=1, result=0, flags=000 one edge after accept; EXEC never entered; ALU result ignored.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid rises (A=8'b11001100, B=8'b10101010, op=0100) -> resp_result=8'b01100110 held stable; req_ready=0 throughout; ops_done unchanged until the handshake.
- Assert rst during EXEC -> next cycle: resp_valid=0, busy=0, pointer=3; no response for the dropped op; next req 0 is granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, scheduler states and flag bit positions shared by the ALU scheduler
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_LAST = OP_CMP;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input logic [N-1:0] req,
  input logic [IW-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    // scan farthest-first so the nearest set bit after ptr wins
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) idx = j;
    end
    grant = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sharing of one external ALU among NUM_REQ requesters,
// one operation in flight, results returned on a tagged valid/ready channel.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int OP_W = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst,
  input logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input logic [NUM_REQ*DATA_W-1:0] req_a,
  input logic [NUM_REQ*DATA_W-1:0] req_b,
  input logic [NUM_REQ*OP_W-1:0] req_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0] alu_opcode,
  input logic [DATA_W-1:0] alu_result,
  input logic alu_overflow,
  input logic alu_negative,
  input logic alu_zero,
  output logic resp_valid,
  input logic resp_ready,
  output logic [ID_W-1:0] resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic [2:0] resp_flags,
  output logic resp_err,
  output logic busy,
  output logic [15:0] ops_done
);
  state_t state, state_nx;
  logic [ID_W-1:0] ptr, idx;
  logic [NUM_REQ-1:0] grant;
  logic [OP_W-1:0] op_sel;
  logic legal, take;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(idx)
  );

  assign op_sel = req_op[idx*OP_W +: OP_W];
  assign legal = op_sel <= OP_W'(OP_LAST);
  assign take = (state == IDLE) && |req_valid;
  assign req_ready = (state == IDLE) ? grant : '0;
  assign resp_valid = state == RESP;
  assign busy = state != IDLE;

  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (take ? (legal ? EXEC : RESP) : IDLE) :
               (state == EXEC) ? RESP :
               (resp_ready ? IDLE : RESP);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  // illegal opcodes skip the ALU and answer with a zeroed error response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= ID_W'(NUM_REQ - 1);
      alu_a <= '0;
      alu_b <= '0;
      alu_opcode <= '0;
      resp_id <= '0;
      resp_result <= '0;
      resp_flags <= '0;
      resp_err <= 1'b0;
      ops_done <= '0;
    end else begin
      if (take) begin
        alu_a <= req_a[idx*DATA_W +: DATA_W];
        alu_b <= req_b[idx*DATA_W +: DATA_W];
        alu_opcode <= op_sel;
        resp_id <= idx;
        ptr <= idx;
        if (!legal) begin
          resp_err <= 1'b1;
          resp_result <= '0;
          resp_flags <= '0;
        end
      end
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_flags[FLAG_V] <= alu_overflow;
        resp_flags[FLAG_N] <= alu_negative;
        resp_flags[FLAG_Z] <= alu_zero;
        resp_err <= 1'b0;
      end
      if (resp_valid && resp_ready) ops_done <= ops_done + 16'd1;
    end
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: randomized and directed checks of alu_scheduler against a transaction-level model
module tb_alu_scheduler;
  localparam int N = 4;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid, req_ready;
  logic [N*8-1:0] req_a, req_b;
  logic [N*4-1:0] req_op;
  logic [7:0] alu_a, alu_b, alu_result, resp_result;
  logic [3:0] alu_opcode;
  logic alu_overflow, alu_negative, alu_zero, resp_valid, resp_ready, resp_err, busy;
  logic [1:0] resp_id;
  logic [2:0] resp_flags;
  logic [15:0] ops_done;
  int checks = 0, errors = 0;
  logic [N-1:0] pend = '0;
  logic [7:0] pa[N], pb[N];
  logic [3:0] pop[N];
  bit drv_ready = 1, mbusy = 0;
  int cyc = 0, acc = 0, lat = 0, mptr = N - 1, ops_exp = 0;
  logic [1:0] e_id;
  logic [7:0] e_a, e_b, e_res;
  logic [3:0] e_op;
  logic [2:0] e_fl;
  logic e_err;
  int glog[$], alog[$];

  always #5 clk = ~clk;

  alu_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
    .busy(busy), .ops_done(ops_done)
  );

  // returns {overflow, negative, zero, result}; illegal opcodes yield junk
  function automatic logic [10:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [3:0] op);
    logic [7:0] r;
    logic v;
    v = 1'b0;
    case (op)
      4'd0: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << 1;
      4'd7: r = a >> 1;
      4'd8: r = {7'b0, a < b};
      default: r = 8'hA5;
    endcase
    return {v, r[7], r == 8'd0, r};
  endfunction

  assign {alu_overflow, alu_negative, alu_zero, alu_result} = alu_fn(alu_a, alu_b, alu_opcode);
  assign req_valid = pend;
  assign resp_ready = drv_ready;
  always_comb
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8] = pa[i];
      req_b[i*8 +: 8] = pb[i];
      req_op[i*4 +: 4] = pop[i];
    end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic issue(int i, logic [7:0] a, logic [7:0] b, logic [3:0] op);
    pa[i] = a;
    pb[i] = b;
    pop[i] = op;
    pend[i] = 1'b1;
  endtask

  // one clock of checking: sample at negedge, advance model, return at posedge+1
  task automatic step();
    int g, taken;
    logic [N-1:0] er;
    @(negedge clk);
    g = -1;
    taken = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
    er = (!mbusy && g >= 0) ? N'(1) << g : '0;
    chk("ready", req_ready, er);
    chk("busy", busy, mbusy && cyc > acc);
    chk("ops", ops_done, ops_exp[15:0]);
    if (mbusy && !e_err && cyc == acc + 1) begin
      chk("alu_a", alu_a, e_a);
      chk("alu_b", alu_b, e_b);
      chk("alu_op", alu_opcode, e_op);
    end
    chk("rvalid", resp_valid, mbusy && cyc >= acc + lat);
    if (resp_valid && mbusy && cyc >= acc + lat) begin
      chk("rid", resp_id, e_id);
      chk("rres", resp_result, e_res);
      chk("rflags", resp_flags, e_fl);
      chk("rerr", resp_err, e_err);
      if (resp_ready) begin
        mbusy = 0;
        ops_exp++;
      end
    end
    if (er != '0) begin
      taken = g;
      mbusy = 1;
      acc = cyc;
      mptr = g;
      e_id = 2'(g);
      e_a = pa[g];
      e_b = pb[g];
      e_op = pop[g];
      e_err = pop[g] > 4'd8;
      lat = e_err ? 1 : 2;
      {e_fl, e_res} = e_err ? 11'd0 : alu_fn(pa[g], pb[g], pop[g]);
      glog.push_back(g);
      alog.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (taken >= 0) pend[taken] = 1'b0;
  endtask

  task automatic run_until_done(int budget);
    int o;
    o = ops_exp;
    for (int n = 0; n < budget && ops_exp == o; n++) step();
    chk("done", ops_exp - o, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && mbusy; n++) step();
    chk("drain", mbusy, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    pend = '0;
    mbusy = 0;
    mptr = N - 1;
    ops_exp = 0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    chk("rst_resp", {resp_id, resp_result, resp_flags, resp_err}, 0);
    chk("rst_ops", ops_done, 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pa[i] = 0;
      pb[i] = 0;
      pop[i] = 0;
    end
    @(posedge clk);
    #1;
    do_reset();
    issue(0, 8'd50, 8'd20, 4'b0000);
    run_until_done(10);
    chk("t1_id", resp_id, 0);
    chk("t1_res", resp_result, 70);
    chk("t1_flags", resp_flags, 0);
    chk("t1_ops", ops_done, 1);
    do_reset();
    glog.delete();
    alog.delete();
    for (int n = 0; n < 40 && glog.size() < 5; n++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) issue(i, 8'($urandom), 8'($urandom), 4'(i + 2));
      step();
    end
    pend = '0;
    drain();
    chk("t2_count", glog.size(), 5);
    for (int k = 0; k < glog.size(); k++) begin
      chk("t2_grant", glog[k], k % N);
      if (k > 0) chk("t2_gap", alog[k] - alog[k-1], 3);
    end
    issue(2, 8'd20, 8'd20, 4'b0001);
    run_until_done(10);
    chk("t3_id", resp_id, 2);
    chk("t3_res", resp_result, 0);
    chk("t3_flags", resp_flags, 3'b001);
    chk("t3_err", resp_err, 0);
    issue(1, 8'd7, 8'd9, 4'b1010);
    run_until_done(10);
    chk("t4_err", resp_err, 1);
    chk("t4_res", {resp_result, resp_flags}, 0);
    issue(0, 8'b11001100, 8'b10101010, 4'b0100);
    drv_ready = 0;
    for (int n = 0; n < 10 && !resp_valid; n++) step();
    chk("t5_valid", resp_valid, 1);
    issue(3, 8'd1, 8'd2, 4'b0000);
    repeat (5) step();
    drv_ready = 1;
    run_until_done(5);
    chk("t5_res", resp_result, 8'b01100110);
    run_until_done(10);
    issue(1, 8'd3, 8'd4, 4'b0000);
    for (int n = 0; n < 10 && !mbusy; n++) step();
    chk("t6_exec", busy, 1);
    do_reset();
    for (int i = 0; i < N; i++) issue(i, 8'($urandom), 8'($urandom), 4'b0010);
    step();
    chk("t6_first", glog[glog.size()-1], 0);
    pend = '0;
    drain();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom % 3 == 0)
          issue(i, 8'($urandom), 8'($urandom),
                ($urandom % 5 == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)));
        else if (pend[i] && $urandom % 25 == 0) pend[i] = 1'b0;
      end
      drv_ready = $urandom % 4 != 0;
      step();
    end
    pend = '0;
    drv_ready = 1;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
